// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants plus helpers shared by the raster generator.
package vga_timing_pkg;

  localparam int unsigned VGA_H_DISP  = 640;
  localparam int unsigned VGA_H_FRONT = 16;
  localparam int unsigned VGA_H_PULSE = 96;
  localparam int unsigned VGA_H_BACK  = 48;
  localparam int unsigned VGA_V_DISP  = 480;
  localparam int unsigned VGA_V_FRONT = 10;
  localparam int unsigned VGA_V_PULSE = 2;
  localparam int unsigned VGA_V_BACK  = 33;

  function automatic int unsigned axis_total(int unsigned disp, int unsigned front,
                                             int unsigned pulse, int unsigned back);
    return disp + front + pulse + back;
  endfunction

  function automatic int unsigned sync_start(int unsigned disp, int unsigned front);
    return disp + front;
  endfunction

  function automatic int unsigned sync_end(int unsigned disp, int unsigned front,
                                           int unsigned pulse);
    return disp + front + pulse - 1;
  endfunction

  // True when a w-bit unsigned counter can represent every value below limit.
  function automatic bit width_fits(int unsigned w, int unsigned limit);
    return (64'd1 << w) >= 64'(limit);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single raster axis counter: counts 0..TOTAL-1 on inc, parks at TOTAL-1 in reset.
// wrap flags the terminal count so the caller can chain the next axis.
module vga_axis_counter #(
  parameter int unsigned TOTAL = 800,
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= LAST;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator; all outputs registered and aligned to (hpos,vpos).
// Optional linear pixel address counter enabled by VGA_TIMING_PIXEL_ADDR_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISP     = VGA_H_DISP,
  parameter int unsigned H_FRONT    = VGA_H_FRONT,
  parameter int unsigned H_PULSE    = VGA_H_PULSE,
  parameter int unsigned H_BACK     = VGA_H_BACK,
  parameter int unsigned V_DISP     = VGA_V_DISP,
  parameter int unsigned V_FRONT    = VGA_V_FRONT,
  parameter int unsigned V_PULSE    = VGA_V_PULSE,
  parameter int unsigned V_BACK     = VGA_V_BACK,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              hsync,
  output logic              vsync,
  output logic [CNT_W-1:0]  hpos,
  output logic [CNT_W-1:0]  vpos,
  output logic              de,
  output logic              line_start,
  output logic              frame_start
`ifdef VGA_TIMING_PIXEL_ADDR_EN
  ,
  output logic [ADDR_W-1:0] pixel_addr
`endif
);

  localparam int unsigned H_TOTAL   = axis_total(H_DISP, H_FRONT, H_PULSE, H_BACK);
  localparam int unsigned V_TOTAL   = axis_total(V_DISP, V_FRONT, V_PULSE, V_BACK);
  localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_start(H_DISP, H_FRONT));
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_end(H_DISP, H_FRONT, H_PULSE));
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_start(V_DISP, V_FRONT));
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_end(V_DISP, V_FRONT, V_PULSE));
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_DISP);

  if (!width_fits(CNT_W, MAX_TOTAL)) begin : g_cnt_w_check
    $error("CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (!width_fits(ADDR_W, H_DISP * V_DISP)) begin : g_addr_w_check
    $error("ADDR_W too narrow for H_DISP*V_DISP-1");
  end

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;

  vga_axis_counter #(.TOTAL(H_TOTAL), .CNT_W(CNT_W)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (enable),
    .cnt   (hpos),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .CNT_W(CNT_W)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (enable & h_wrap),
    .cnt   (vpos),
    .wrap  (v_wrap)
  );

  // Decode from the position the counters move to, so flags land with it.
  assign h_nxt = h_wrap ? '0 : hpos + 1'b1;
  assign v_nxt = h_wrap ? (v_wrap ? '0 : vpos + 1'b1) : vpos;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      hsync       <= (h_nxt >= HS_START && h_nxt <= HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= (v_nxt >= VS_START && v_nxt <= VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
      de          <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_PIXEL_ADDR_EN
  // Advances when leaving an active pixel, so it already points at the next one in blanking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pixel_addr <= '0;
    end else if (enable) begin
      if (h_wrap && v_wrap) begin
        pixel_addr <= '0;
      end else if (de) begin
        pixel_addr <= pixel_addr + 1'b1;
      end
    end
  end
`else
  // Without the address counter downstream logic derives addresses from hpos/vpos.
`endif

endmodule
